mem_port_arbiter: RTL and testbench

//  Shares one single-ported unified memory between the pipeline's instruction-fetch (IF) and data (MEM) requesters.

---
 rtl/mem_arb_pkg.sv | 11 +
 rtl/mem_arb_select.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings for the unified-memory port arbiter.
//   state_t : arbiter FSM states (IDLE, ISSUE, RESP)
//   owner_t : which requester owns the transaction in flight (NONE, IF, DATA)
//   MASK_*  : funct3[1:0] maskmode values driven on mem_mask
package mem_arb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DATA} owner_t;
  localparam logic [1:0] MASK_BYTE = 2'd0;
  localparam logic [1:0] MASK_HALF = 2'd1;
  localparam logic [1:0] MASK_WORD = 2'd2;
endpackage

// File: rtl/mem_arb_select.sv
// mem_arb_select: combinational priority pick between fetch and data requests.
//   Optional macro ARB_STARVE_GUARD_EN adds a counter of consecutive data grants
//   made while fetch is waiting; at STARVE_LIMIT the next pick goes to fetch.
// Ports:
//   clk, rstn  clock / sync active-low reset (ARB_STARVE_GUARD_EN only)
//   i_arb      an arbitration is taken this cycle (ARB_STARVE_GUARD_EN only)
//   i_if_req   fetch request
//   i_d_req    data request
//   o_pick     winning owner, OWN_NONE when nobody requests
module mem_arb_select
  import mem_arb_pkg::*;
`ifdef ARB_STARVE_GUARD_EN
#(
  parameter int STARVE_LIMIT = 4
)
`endif
(
`ifdef ARB_STARVE_GUARD_EN
  input  logic   clk,
  input  logic   rstn,
  input  logic   i_arb,
`endif
  input  logic   i_if_req,
  input  logic   i_d_req,
  output owner_t o_pick
);
`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] r_cnt;
  logic          w_force;
  assign w_force = i_if_req && (r_cnt >= CW'(STARVE_LIMIT));
  assign o_pick = w_force ? OWN_IF : i_d_req ? OWN_DATA : i_if_req ? OWN_IF : OWN_NONE;
  // Counts only while fetch is actually waiting; any fetch grant or idle fetch restarts it.
  always_ff @(posedge clk) begin
    if (!rstn || !i_if_req)
      r_cnt <= '0;
    else if (i_arb)
      r_cnt <= (o_pick == OWN_IF) ? '0 : (o_pick == OWN_DATA) ? r_cnt + 1'b1 : r_cnt;
  end
`else
  assign o_pick = i_d_req ? OWN_DATA : i_if_req ? OWN_IF : OWN_NONE;
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises IF fetches and MEM loads/stores onto one memory port.
//   One transaction at a time, data side wins. Optional macro ARB_STARVE_GUARD_EN
//   forces a fetch grant after STARVE_LIMIT consecutive data grants.
// Ports:
//   clk, rstn                      clock / sync active-low reset
//   i_if_req, i_if_addr            fetch request and PC
//   o_if_rdata, o_if_ack           fetched instruction, 1-cycle completion pulse
//   i_d_req, i_d_we, i_d_addr,
//   i_d_wdata, i_d_mask, i_d_sext  data request fields
//   o_d_rdata, o_d_ack             load data, 1-cycle completion pulse
//   o_mem_req, o_mem_we, o_mem_addr,
//   o_mem_wdata, o_mem_mask, o_mem_sext  registered request to memory
//   i_mem_gnt, i_mem_rvalid, i_mem_rdata memory handshake and read data
//   o_stall_if, o_stall_mem        requester waiting, to the hazard unit
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
`ifdef ARB_STARVE_GUARD_EN
  , parameter int STARVE_LIMIT = 4
`endif
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_if_req,
  input  logic [ADDR_WIDTH-1:0] i_if_addr,
  output logic [DATA_WIDTH-1:0] o_if_rdata,
  output logic                  o_if_ack,
  input  logic                  i_d_req,
  input  logic                  i_d_we,
  input  logic [ADDR_WIDTH-1:0] i_d_addr,
  input  logic [DATA_WIDTH-1:0] i_d_wdata,
  input  logic [1:0]            i_d_mask,
  input  logic                  i_d_sext,
  output logic [DATA_WIDTH-1:0] o_d_rdata,
  output logic                  o_d_ack,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic [1:0]            o_mem_mask,
  output logic                  o_mem_sext,
  input  logic                  i_mem_gnt,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_stall_if,
  output logic                  o_stall_mem
);
  state_t                r_state;
  owner_t                r_owner;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [1:0]            r_mem_mask;
  logic                  r_mem_sext;
  logic [DATA_WIDTH-1:0] r_if_rdata;
  logic [DATA_WIDTH-1:0] r_d_rdata;
  logic                  r_if_ack;
  logic                  r_d_ack;
  logic                  w_arb;
  owner_t                w_pick;
  // A requester still holds req during its ack cycle; skip arbitration then so
  // the finished request is not issued a second time.
  assign w_arb = (r_state == S_IDLE) && !r_if_ack && !r_d_ack;
`ifdef ARB_STARVE_GUARD_EN
  mem_arb_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_sel (
    .clk      (clk),
    .rstn     (rstn),
    .i_arb    (w_arb),
    .i_if_req (i_if_req),
    .i_d_req  (i_d_req),
    .o_pick   (w_pick)
  );
`else
  mem_arb_select u_sel (
    .i_if_req (i_if_req),
    .i_d_req  (i_d_req),
    .o_pick   (w_pick)
  );
`endif
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_owner     <= OWN_NONE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_mask  <= '0;
      r_mem_sext  <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_ack    <= 1'b0;
      r_d_ack     <= 1'b0;
    end else begin
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_arb && w_pick != OWN_NONE) begin
            r_owner     <= w_pick;
            r_state     <= S_ISSUE;
            r_mem_req   <= 1'b1;
            r_mem_we    <= (w_pick == OWN_DATA) ? i_d_we : 1'b0;
            r_mem_addr  <= (w_pick == OWN_DATA) ? i_d_addr : i_if_addr;
            r_mem_wdata <= (w_pick == OWN_DATA) ? i_d_wdata : '0;
            r_mem_mask  <= (w_pick == OWN_DATA) ? i_d_mask : MASK_WORD;
            r_mem_sext  <= (w_pick == OWN_DATA) ? i_d_sext : 1'b0;
          end
        end
        S_ISSUE: begin
          if (i_mem_gnt) begin
            r_mem_req <= 1'b0;
            r_state   <= S_RESP;
          end
        end
        S_RESP: begin
          if (i_mem_rvalid) begin
            if (r_owner == OWN_IF) begin
              r_if_rdata <= i_mem_rdata;
              r_if_ack   <= 1'b1;
            end else begin
              if (!r_mem_we)
                r_d_rdata <= i_mem_rdata;
              r_d_ack <= 1'b1;
            end
            r_owner <= OWN_NONE;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign o_if_rdata  = r_if_rdata;
  assign o_if_ack    = r_if_ack;
  assign o_d_rdata   = r_d_rdata;
  assign o_d_ack     = r_d_ack;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_mask  = r_mem_mask;
  assign o_mem_sext  = r_mem_sext;
  assign o_stall_if  = i_if_req & ~r_if_ack;
  assign o_stall_mem = i_d_req & ~r_d_ack;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        i_if_req = 1'b0;
  logic [31:0] i_if_addr = '0;
  logic [31:0] o_if_rdata;
  logic        o_if_ack;
  logic        i_d_req = 1'b0;
  logic        i_d_we = 1'b0;
  logic [31:0] i_d_addr = '0;
  logic [31:0] i_d_wdata = '0;
  logic [1:0]  i_d_mask = '0;
  logic        i_d_sext = 1'b0;
  logic [31:0] o_d_rdata;
  logic        o_d_ack;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [1:0]  o_mem_mask;
  logic        o_mem_sext;
  logic        i_mem_gnt = 1'b0;
  logic        i_mem_rvalid = 1'b0;
  logic [31:0] i_mem_rdata = '0;
  logic        o_stall_if;
  logic        o_stall_mem;
  int tests = 0;
  int fails = 0;

  mem_port_arbiter dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_if_req     (i_if_req),
    .i_if_addr    (i_if_addr),
    .o_if_rdata   (o_if_rdata),
    .o_if_ack     (o_if_ack),
    .i_d_req      (i_d_req),
    .i_d_we       (i_d_we),
    .i_d_addr     (i_d_addr),
    .i_d_wdata    (i_d_wdata),
    .i_d_mask     (i_d_mask),
    .i_d_sext     (i_d_sext),
    .o_d_rdata    (o_d_rdata),
    .o_d_ack      (o_d_ack),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_mask   (o_mem_mask),
    .o_mem_sext   (o_mem_sext),
    .i_mem_gnt    (i_mem_gnt),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata),
    .o_stall_if   (o_stall_if),
    .o_stall_mem  (o_stall_mem)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    tick;
    tick;
    tests++; if (o_mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req got %b expected 0", o_mem_req); end
    tests++; if ({o_if_ack, o_d_ack} !== 2'b00) begin fails++; $display("FAIL reset_acks got %b expected 00", {o_if_ack, o_d_ack}); end
    tests++; if ({o_mem_addr, o_mem_wdata, o_if_rdata, o_d_rdata} !== 128'h0) begin fails++; $display("FAIL reset_data got %h expected 0", {o_mem_addr, o_mem_wdata, o_if_rdata, o_d_rdata}); end
    rstn = 1'b1;
    tick;
  endtask

  task automatic test_fetch_latency;
    i_if_req = 1'b1; i_if_addr = 32'h10; i_mem_gnt = 1'b1; #1;
    tests++; if (o_stall_if !== 1'b1) begin fails++; $display("FAIL fetch_stall_c0 got %b expected 1", o_stall_if); end
    tick;
    tests++; if ({o_mem_req, o_mem_we, o_mem_addr} !== {1'b1, 1'b0, 32'h10}) begin fails++; $display("FAIL fetch_issue got %b/%b/%h expected 1/0/00000010", o_mem_req, o_mem_we, o_mem_addr); end
    tests++; if (o_stall_if !== 1'b1) begin fails++; $display("FAIL fetch_stall_c1 got %b expected 1", o_stall_if); end
    tick;
    tests++; if ({o_mem_req, o_if_ack} !== 2'b00) begin fails++; $display("FAIL fetch_resp got req/ack %b expected 00", {o_mem_req, o_if_ack}); end
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h00500093; #1;
    tests++; if (o_stall_if !== 1'b1) begin fails++; $display("FAIL fetch_stall_c2 got %b expected 1", o_stall_if); end
    tick;
    tests++; if ({o_if_ack, o_if_rdata} !== {1'b1, 32'h00500093}) begin fails++; $display("FAIL fetch_ack got %b/%h expected 1/00500093", o_if_ack, o_if_rdata); end
    tests++; if (o_stall_if !== 1'b0) begin fails++; $display("FAIL fetch_stall_c3 got %b expected 0", o_stall_if); end
    i_if_req = 1'b0; i_mem_rvalid = 1'b0;
    tick;
    tests++; if (o_if_ack !== 1'b0) begin fails++; $display("FAIL fetch_ack_pulse got %b expected 0", o_if_ack); end
  endtask

  task automatic test_priority;
    i_if_req = 1'b1; i_if_addr = 32'h40;
    i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = 32'h100; i_d_mask = 2'd2; i_d_sext = 1'b1;
    tick;
    tests++; if ({o_mem_req, o_mem_we, o_mem_addr, o_mem_sext} !== {1'b1, 1'b0, 32'h100, 1'b1}) begin fails++; $display("FAIL prio_data_first got %b/%b/%h/%b expected 1/0/00000100/1", o_mem_req, o_mem_we, o_mem_addr, o_mem_sext); end
    i_mem_gnt = 1'b1;
    tick;
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'hCAFE0001;
    tick;
    tests++; if ({o_d_ack, o_if_ack, o_d_rdata} !== {1'b1, 1'b0, 32'hCAFE0001}) begin fails++; $display("FAIL prio_d_ack got %b/%b/%h expected 1/0/cafe0001", o_d_ack, o_if_ack, o_d_rdata); end
    i_d_req = 1'b0; i_mem_rvalid = 1'b0;
    tick;
    tests++; if (o_mem_req !== 1'b0) begin fails++; $display("FAIL prio_no_overlap got %b expected 0", o_mem_req); end
    tick;
    tests++; if ({o_mem_req, o_mem_addr, o_mem_mask} !== {1'b1, 32'h40, 2'd2}) begin fails++; $display("FAIL prio_fetch_next got %b/%h/%0d expected 1/00000040/2", o_mem_req, o_mem_addr, o_mem_mask); end
    i_mem_gnt = 1'b1;
    tick;
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h00000013;
    tick;
    tests++; if ({o_if_ack, o_if_rdata, o_d_rdata} !== {1'b1, 32'h13, 32'hCAFE0001}) begin fails++; $display("FAIL prio_if_ack got %b/%h/%h expected 1/00000013/cafe0001", o_if_ack, o_if_rdata, o_d_rdata); end
    i_if_req = 1'b0; i_mem_rvalid = 1'b0;
    tick;
  endtask

  task automatic test_store_hold;
    i_d_req = 1'b1; i_d_we = 1'b1; i_d_addr = 32'h20; i_d_wdata = 32'hDEADBEEF; i_d_mask = 2'd2; i_d_sext = 1'b0;
    tick;
    for (int c = 0; c < 4; c++) begin
      tests++; if ({o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_mask} !== {1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 2'd2}) begin fails++; $display("FAIL store_hold_%0d got %b/%b/%h/%h/%0d expected 1/1/00000020/deadbeef/2", c, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_mask); end
      tick;
    end
    i_mem_gnt = 1'b1;
    tick;
    tests++; if (o_mem_req !== 1'b0) begin fails++; $display("FAIL store_req_drop got %b expected 0", o_mem_req); end
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h12345678;
    tick;
    tests++; if ({o_d_ack, o_d_rdata} !== {1'b1, 32'hCAFE0001}) begin fails++; $display("FAIL store_ack got %b/%h expected 1/cafe0001", o_d_ack, o_d_rdata); end
    i_d_req = 1'b0; i_d_we = 1'b0; i_mem_rvalid = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid;
    i_if_req = 1'b1; i_if_addr = 32'h30;
    tick;
    i_mem_gnt = 1'b1;
    tick;
    i_mem_gnt = 1'b0; rstn = 1'b0; i_if_req = 1'b0;
    tick;
    tests++; if ({o_mem_req, o_mem_we, o_if_ack, o_d_ack} !== 4'b0000) begin fails++; $display("FAIL rst_mid_ctrl got %b expected 0000", {o_mem_req, o_mem_we, o_if_ack, o_d_ack}); end
    tests++; if ({o_mem_addr, o_if_rdata, o_d_rdata} !== 96'h0) begin fails++; $display("FAIL rst_mid_data got %h expected 0", {o_mem_addr, o_if_rdata, o_d_rdata}); end
    rstn = 1'b1; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h55555555;
    tick;
    tests++; if ({o_if_ack, o_d_ack, o_if_rdata} !== {2'b00, 32'h0}) begin fails++; $display("FAIL rst_late_rvalid got %b/%h expected 00/00000000", {o_if_ack, o_d_ack}, o_if_rdata); end
    i_mem_rvalid = 1'b0;
    tick;
  endtask

  task automatic test_spurious;
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'h77777777;
    tick;
    tests++; if ({o_if_ack, o_d_ack, o_mem_req} !== 3'b000) begin fails++; $display("FAIL spur_rvalid_idle got %b expected 000", {o_if_ack, o_d_ack, o_mem_req}); end
    i_mem_rvalid = 1'b0;
    i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = 32'h44;
    tick;
    i_mem_gnt = 1'b1;
    tick;
    tick;
    tests++; if ({o_d_ack, o_mem_req} !== 2'b00) begin fails++; $display("FAIL spur_gnt_resp got %b expected 00", {o_d_ack, o_mem_req}); end
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h0BADF00D;
    tick;
    tests++; if ({o_d_ack, o_d_rdata} !== {1'b1, 32'h0BADF00D}) begin fails++; $display("FAIL spur_then_ack got %b/%h expected 1/0badf00d", o_d_ack, o_d_rdata); end
    i_d_req = 1'b0; i_mem_rvalid = 1'b0;
    tick;
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_addr;
    int n;
    i_if_req = 1'b1; i_if_addr = 32'h80;
    i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = 32'h200;
    for (int g = 0; g < 5; g++) begin
`ifdef ARB_STARVE_GUARD_EN
      exp_addr = (g == 4) ? 32'h80 : 32'h200;
`else
      exp_addr = 32'h200;
`endif
      n = 0;
      while (!o_mem_req && n < 10) begin tick; n++; end
      tests++; if (o_mem_addr !== exp_addr || o_mem_req !== 1'b1) begin fails++; $display("FAIL b2b_grant_%0d got req %b addr %h expected 1/%h", g, o_mem_req, o_mem_addr, exp_addr); end
      i_mem_gnt = 1'b1;
      tick;
      i_mem_gnt = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h1000 + g;
      tick;
      i_mem_rvalid = 1'b0;
      if (o_if_ack) i_if_req = 1'b0;
    end
    i_if_req = 1'b0; i_d_req = 1'b0;
    tick;
    tick;
  endtask

  initial begin
    test_reset;
    test_fetch_latency;
    test_priority;
    test_store_hold;
    test_reset_mid;
    test_spurious;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
